// File: rtl/spi_arbiter_pkg.sv
// Shared types for the SPI arbiter: slave selects, arbiter states, default timeouts.
package spi_arbiter_pkg;

  typedef enum logic [2:0] {
    SS_NONE,
    SS_EEPROM,
    SS_CH1,
    SS_CH2,
    SS_CH3,
    SS_TRIGGER
  } SlaveSelect;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } arb_state_t;

  localparam int unsigned HOLD_TIMEOUT_DEF = 16;
  localparam int unsigned DONE_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester and SPI-master signals of the arbiter, bundled for port connection.
interface spi_arbiter_if;
  import spi_arbiter_pkg::*;

  logic        req0, lock0, gnt0, done0;
  SlaveSelect  ss0;
  logic [15:0] data0;
  logic        req1, lock1, gnt1, done1;
  SlaveSelect  ss1;
  logic [15:0] data1;

  logic        wrt_SPI;
  SlaveSelect  ss;
  logic [15:0] SPI_data;
  logic        SPI_done;
  logic [7:0]  EEP_data;
  logic [7:0]  rd_data;
  logic        spurious_done;
  logic        timeout_err;

  modport slave (
    input  req0, lock0, ss0, data0, req1, lock1, ss1, data1, SPI_done, EEP_data,
    output gnt0, done0, gnt1, done1, wrt_SPI, ss, SPI_data, rd_data,
           spurious_done, timeout_err
  );

  modport master (
    output req0, lock0, ss0, data0, req1, lock1, ss1, data1, SPI_done, EEP_data,
    input  gnt0, done0, gnt1, done1, wrt_SPI, ss, SPI_data, rd_data,
           spurious_done, timeout_err
  );

endinterface

// File: rtl/spi_arb_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module spi_arb_timer #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter with lock sharing one SPI master between two requesters.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_TIMEOUT = HOLD_TIMEOUT_DEF,
  parameter int unsigned DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
  input logic          clk,
  input logic          rst_n,
  spi_arbiter_if.slave bus
);

  localparam int unsigned TW =
    $clog2((HOLD_TIMEOUT > DONE_TIMEOUT) ? HOLD_TIMEOUT : DONE_TIMEOUT) + 1;

  arb_state_t  state, state_d;
  logic        owner, owner_d, lk, lk_d, last, last_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
  logic        wrt_q, wrt_d, spur_q, spur_d, tout_q, tout_d;
  SlaveSelect  ss_q, ss_d;
  logic [15:0] spi_data_q, spi_data_d;
  logic [7:0]  rd_q, rd_d;
  logic        issue, sel;
  logic        t_load, t_expired;
  logic [TW-1:0] t_val;

  spi_arb_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .expired  (t_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      lk         <= 1'b0;
      last       <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      wrt_q      <= 1'b0;
      spur_q     <= 1'b0;
      tout_q     <= 1'b0;
      ss_q       <= SS_NONE;
      spi_data_q <= '0;
      rd_q       <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      lk         <= lk_d;
      last       <= last_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      wrt_q      <= wrt_d;
      spur_q     <= spur_d;
      tout_q     <= tout_d;
      ss_q       <= ss_d;
      spi_data_q <= spi_data_d;
      rd_q       <= rd_d;
    end
  end

  always_comb begin
    state_d    = state;
    owner_d    = owner;
    lk_d       = lk;
    last_d     = last;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    wrt_d      = 1'b0;
    spur_d     = spur_q;
    tout_d     = tout_q;
    ss_d       = ss_q;
    spi_data_d = spi_data_q;
    rd_d       = rd_q;
    issue      = 1'b0;
    sel        = owner;

    unique case (state)
      IDLE: begin
        if (bus.SPI_done) spur_d = 1'b1;
        if (bus.req0 && bus.req1) begin
          issue = 1'b1;
          sel   = ~last;
        end else if (bus.req0) begin
          issue = 1'b1;
          sel   = 1'b0;
        end else if (bus.req1) begin
          issue = 1'b1;
          sel   = 1'b1;
        end
      end
      WAIT: begin
        if (bus.SPI_done || t_expired) begin
          done0_d = ~owner;
          done1_d = owner;
          ss_d    = SS_NONE;
          if (bus.SPI_done) begin
            rd_d    = bus.EEP_data;
            state_d = lk ? HOLD : IDLE;
          end else begin
            tout_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (bus.SPI_done) spur_d = 1'b1;
        if (owner ? bus.req1 : bus.req0) begin
          issue = 1'b1;
          sel   = owner;
        end else if (t_expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Issue path shared by IDLE arbitration and the locked owner's HOLD re-request.
    if (issue) begin
      state_d    = WAIT;
      owner_d    = sel;
      last_d     = sel;
      wrt_d      = 1'b1;
      gnt0_d     = ~sel;
      gnt1_d     = sel;
      lk_d       = sel ? bus.lock1 : bus.lock0;
      ss_d       = sel ? bus.ss1 : bus.ss0;
      spi_data_d = sel ? bus.data1 : bus.data0;
    end

    t_load = (state_d != state);
    unique case (state_d)
      WAIT:    t_val = TW'(DONE_TIMEOUT - 1);
      HOLD:    t_val = TW'(HOLD_TIMEOUT - 1);
      default: t_val = '0;
    endcase
  end

  assign bus.gnt0          = gnt0_q;
  assign bus.gnt1          = gnt1_q;
  assign bus.done0         = done0_q;
  assign bus.done1         = done1_q;
  assign bus.wrt_SPI       = wrt_q;
  assign bus.ss            = ss_q;
  assign bus.SPI_data      = spi_data_q;
  assign bus.rd_data       = rd_q;
  assign bus.spurious_done = spur_q;
  assign bus.timeout_err   = tout_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: stimulus/SPI-master model push expectations, monitor pops and compares.
module tb_spi_arbiter;
  import spi_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  spi_arbiter_if bus ();

  spi_arbiter #(.HOLD_TIMEOUT(16), .DONE_TIMEOUT(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          who;
    SlaveSelect  ss;
    logic [15:0] data;
    int          rel;   // 0: at is absolute cycle, 1: at is offset from last done
    int          at;
  } gnt_exp_t;

  typedef struct {
    int         who;
    logic [7:0] rd;
    int         at;
    logic       tout;
  } done_exp_t;

  gnt_exp_t  gq[$];
  done_exp_t dq[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_done_cyc = 0, exp_owner = 0;
  int spi_cnt = 0, dly_lo = 1, dly_hi = 8, eep_force = -1;
  int model_last = 1;
  logic [7:0] model_rd = '0;
  logic mute = 1'b0, tail_lock = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // One clock step: requester drop-after-grant and the SPI master response model.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (bus.gnt0) bus.req0 = 1'b0;
    if (bus.gnt1) bus.req1 = 1'b0;
    bus.SPI_done = 1'b0;
    bus.EEP_data = 8'($urandom);
    if (spi_cnt > 0) begin
      spi_cnt--;
      if (spi_cnt == 0) begin
        if (eep_force >= 0) bus.EEP_data = 8'(eep_force);
        bus.SPI_done = 1'b1;
        model_rd = bus.EEP_data;
        dq.push_back('{who: exp_owner, rd: bus.EEP_data, at: cyc + 1, tout: 1'b0});
      end
    end
    if (bus.wrt_SPI && !mute)
      spi_cnt = (dly_lo == dly_hi) ? dly_lo : int'($urandom_range(dly_hi, dly_lo));
  endtask

  task automatic raise(int who, SlaveSelect s, logic [15:0] d, logic lk);
    if (who == 0) begin
      bus.req0 = 1'b1; bus.ss0 = s; bus.data0 = d; bus.lock0 = lk;
    end else begin
      bus.req1 = 1'b1; bus.ss1 = s; bus.data1 = d; bus.lock1 = lk;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(gq.size() == 0 && dq.size() == 0 && !bus.req0 && !bus.req1 && spi_cnt == 0 &&
             cyc >= last_done_cyc + (tail_lock ? 16 : 0)) && n < 3000) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(n < 3000), 1);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.SPI_done = 1'b0;
    gq.delete(); dq.delete();
    spi_cnt = 0; model_last = 1; model_rd = '0; tail_lock = 1'b0; last_done_cyc = cyc;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_reset(string tag);
    check({tag, "_gnt"},  {bus.gnt1, bus.gnt0}, 0);
    check({tag, "_done"}, {bus.done1, bus.done0}, 0);
    check({tag, "_wrt"},  bus.wrt_SPI, 0);
    check({tag, "_ss"},   bus.ss, SS_NONE);
    check({tag, "_data"}, bus.SPI_data, 0);
    check({tag, "_rd"},   bus.rd_data, 0);
    check({tag, "_flags"}, {bus.spurious_done, bus.timeout_err}, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or done.
  initial forever begin
    gnt_exp_t  g;
    done_exp_t d;
    @(negedge clk);
    if (rst_n) begin
      if (bus.gnt0 || bus.gnt1 || bus.wrt_SPI) begin
        if (gq.size() == 0) check("unexpected_grant", {bus.wrt_SPI, bus.gnt1, bus.gnt0}, 0);
        else begin
          g = gq.pop_front();
          check("gnt_who", {bus.gnt1, bus.gnt0}, (g.who != 0) ? 2 : 1);
          check("gnt_wrt", bus.wrt_SPI, 1);
          check("gnt_ss", bus.ss, g.ss);
          check("gnt_data", bus.SPI_data, g.data);
          check("gnt_cycle", cyc, (g.rel != 0) ? last_done_cyc + g.at : g.at);
          exp_owner = g.who;
        end
      end
      if (bus.done0 || bus.done1) begin
        if (dq.size() == 0) check("unexpected_done", {bus.done1, bus.done0}, 0);
        else begin
          d = dq.pop_front();
          check("done_who", {bus.done1, bus.done0}, (d.who != 0) ? 2 : 1);
          check("done_rd", bus.rd_data, d.rd);
          check("done_cycle", cyc, d.at);
          check("done_ss", bus.ss, SS_NONE);
          check("done_tout", bus.timeout_err, d.tout);
        end
        last_done_cyc = cyc;
      end
    end
  end

  initial begin
    SlaveSelect  rs[2];
    logic [15:0] rdat[2];
    logic        rl[2];
    int mask, w, l, k;
    logic seen;

    bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0;
    bus.ss0 = SS_NONE; bus.ss1 = SS_NONE; bus.data0 = '0; bus.data1 = '0;
    bus.SPI_done = 0; bus.EEP_data = '0;
    do_reset();
    check_reset("reset");

    // Single EEPROM transfer, 20-cycle SPI latency.
    dly_lo = 20; dly_hi = 20; eep_force = 8'h3C;
    raise(0, SS_EEPROM, 16'h4A55, 1'b0);
    gq.push_back('{who: 0, ss: SS_EEPROM, data: 16'h4A55, rel: 0, at: cyc + 1});
    model_last = 0; tail_lock = 0;
    wait_idle();
    check("rd_after_plain", bus.rd_data, 8'h3C);
    dly_lo = 1; dly_hi = 8; eep_force = -1;

    // Ties after reset alternate 0,1,0,1.
    do_reset();
    repeat (2) begin
      for (int i = 0; i < 2; i++) begin
        rs[i] = SlaveSelect'($urandom_range(5, 1)); rdat[i] = 16'($urandom);
      end
      w = (model_last == 0) ? 1 : 0; l = 1 - w;
      gq.push_back('{who: w, ss: rs[w], data: rdat[w], rel: 0, at: cyc + 1});
      gq.push_back('{who: l, ss: rs[l], data: rdat[l], rel: 1, at: 1});
      model_last = l; tail_lock = 0;
      raise(0, rs[0], rdat[0], 1'b0);
      raise(1, rs[1], rdat[1], 1'b0);
      wait_idle();
    end

    // Locked requester 1 chains a second transfer ahead of pending requester 0.
    raise(1, SS_CH2, 16'h1111, 1'b1);
    gq.push_back('{who: 1, ss: SS_CH2, data: 16'h1111, rel: 0, at: cyc + 1});
    tick();
    raise(0, SS_TRIGGER, 16'h2222, 1'b0);
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      seen = bus.done1;
    end
    check("lock_done1_seen", 32'(seen), 1);
    k = $urandom_range(4, 1);
    repeat (k) tick();
    raise(1, SS_CH3, 16'h3333, 1'b0);
    gq.push_back('{who: 1, ss: SS_CH3, data: 16'h3333, rel: 0, at: cyc + 1});
    gq.push_back('{who: 0, ss: SS_TRIGGER, data: 16'h2222, rel: 1, at: 1});
    model_last = 0; tail_lock = 0;
    wait_idle();

    // Locked owner without follow-up: HOLD lasts 16 cycles, then pending req1.
    raise(0, SS_CH1, 16'hA0A0, 1'b1);
    gq.push_back('{who: 0, ss: SS_CH1, data: 16'hA0A0, rel: 0, at: cyc + 1});
    gq.push_back('{who: 1, ss: SS_EEPROM, data: 16'h0B0B, rel: 1, at: 17});
    tick();
    raise(1, SS_EEPROM, 16'h0B0B, 1'b0);
    model_last = 1; tail_lock = 0;
    wait_idle();

    // Randomized rounds.
    for (int r = 0; r < 25; r++) begin
      mask = $urandom_range(3, 1);
      for (int i = 0; i < 2; i++) begin
        rs[i] = SlaveSelect'($urandom_range(5, 1));
        rdat[i] = 16'($urandom);
        rl[i] = ($urandom_range(3, 0) == 0);
      end
      if (mask == 3) begin
        w = (model_last == 0) ? 1 : 0; l = 1 - w;
        gq.push_back('{who: w, ss: rs[w], data: rdat[w], rel: 0, at: cyc + 1});
        gq.push_back('{who: l, ss: rs[l], data: rdat[l], rel: 1, at: rl[w] ? 17 : 1});
        model_last = l; tail_lock = rl[l];
        raise(0, rs[0], rdat[0], rl[0]);
        raise(1, rs[1], rdat[1], rl[1]);
      end else begin
        w = mask - 1;
        gq.push_back('{who: w, ss: rs[w], data: rdat[w], rel: 0, at: cyc + 1});
        model_last = w; tail_lock = rl[w];
        raise(w, rs[w], rdat[w], rl[w]);
      end
      wait_idle();
    end

    // SPI_done while idle sets the sticky flag only.
    bus.SPI_done = 1'b1;
    tick();
    check("spurious_set", bus.spurious_done, 1);
    raise(1, SS_CH1, 16'h5A5A, 1'b0);
    gq.push_back('{who: 1, ss: SS_CH1, data: 16'h5A5A, rel: 0, at: cyc + 1});
    model_last = 1; tail_lock = 0;
    wait_idle();
    check("spurious_sticky", bus.spurious_done, 1);

    // SPI master never answers: abort after DONE_TIMEOUT.
    mute = 1'b1;
    raise(0, SS_EEPROM, 16'hC0DE, 1'b0);
    gq.push_back('{who: 0, ss: SS_EEPROM, data: 16'hC0DE, rel: 0, at: cyc + 1});
    dq.push_back('{who: 0, rd: model_rd, at: cyc + 1025, tout: 1'b1});
    model_last = 0; tail_lock = 0;
    wait_idle();
    check("timeout_sticky", bus.timeout_err, 1);
    do_reset();
    check_reset("reset_clears_flags");

    // Reset asserted mid-WAIT takes effect immediately.
    raise(1, SS_TRIGGER, 16'hBEEF, 1'b1);
    gq.push_back('{who: 1, ss: SS_TRIGGER, data: 16'hBEEF, rel: 0, at: cyc + 1});
    repeat (40) tick();
    #2 rst_n = 1'b0;
    #1 check_reset("mid_wait_reset");
    do_reset();
    mute = 1'b0;
    repeat (4) tick();

    check("gnt_queue_drained", gq.size(), 0);
    check("done_queue_drained", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares the single SPI master (EEPROM, gain DACs, trigger DAC) between two requesters.
  - Requester 0: command dispatcher.
  - Requester 1: background calibration/refresh engine.
- Round-robin arbitration with an optional lock, so a multi-transfer sequence (EEPROM read = address transfer + dummy transfer) is never split.
- Holds slave select stable for the whole transfer.
- Returns the read byte and a done pulse to the owning requester.

Parameters:
HOLD_TIMEOUT, 16, max cycles a locked owner may idle in HOLD before the bus is released.
DONE_TIMEOUT, 1024, max cycles in WAIT without SPI_done before the transfer is aborted.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 transaction request (level; held until gnt0)
lock0  in  1  requester 0 keeps ownership after this transfer
ss0  in  SlaveSelect  requester 0 target slave
data0  in  16  requester 0 SPI word
gnt0  out  1  one-cycle pulse: request 0 accepted
done0  out  1  one-cycle pulse: request 0 transfer complete
req1, lock1, ss1, data1, gnt1, done1  same as above, requester 1
wrt_SPI  out  1  one-cycle start pulse to SPI master
ss  out  SlaveSelect  slave select to SPI master
SPI_data  out  16  word to SPI master
SPI_done  in  1  SPI master transfer complete (one-cycle)
EEP_data  in  8  byte received by SPI master
rd_data  out  8  captured EEP_data, valid in the done0/done1 cycle
spurious_done  out  1  sticky: SPI_done seen while not in WAIT
timeout_err  out  1  sticky: WAIT exceeded DONE_TIMEOUT

Behaviour:
- All outputs registered.
- Reset values:
  - gnt/done/wrt_SPI = 0, ss = SS_NONE, SPI_data = 0, rd_data = 0.
  - Sticky flags = 0, state = IDLE.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
- States: IDLE, WAIT, HOLD.
- IDLE:
  - Single request x: at the next edge set wrt_SPI=1, gntx=1, ss=ssx, SPI_data=datax.
  - Also latch owner=x and lk=lockx, and go to WAIT.
  - Both requesting: grant the one != last. Set last=owner on grant.
  - Latency: req sampled in cycle N gives wrt_SPI/gnt in N+1.
- WAIT:
  - wrt_SPI=0 after its single cycle; ss and SPI_data held.
  - All req inputs ignored; non-owner requests remain pending.
  - On SPI_done in cycle M: in M+1 assert doneowner=1, rd_data=EEP_data(M), ss=SS_NONE. Then go to HOLD if lk, else IDLE.
  - Counter reaches DONE_TIMEOUT: set timeout_err, pulse doneowner (rd_data unchanged), ss=SS_NONE, go IDLE.
- HOLD:
  - ss=SS_NONE, which provides the deselect gap between chained transfers.
  - reqowner: issue exactly as from IDLE without arbitration, relatching lk from lockowner.
  - Non-owner requests ignored.
  - HOLD_TIMEOUT cycles without reqowner: go IDLE; a pending request is granted on the following edge.
- Requester rules:
  - ssx and datax must be stable while reqx=1.
  - Requester deasserts or changes reqx the cycle after gntx.
  - A reqx still high in IDLE after gntx is treated as a new request (requester's responsibility).
- SPI_done in IDLE or HOLD: no done pulse, set spurious_done.
- Timeout counter width = clog2(max(HOLD_TIMEOUT, DONE_TIMEOUT)) + 1. It is cleared on every state entry.
- Reset asserted mid-WAIT/HOLD: immediate return to reset values. Any in-flight SPI transfer is abandoned, with no done pulse.

Decomposition:
- SlaveSelect enum (SS_NONE, SS_EEPROM, SS_CH1..3, SS_TRIGGER) stays in the shared types include.
- Add the arbiter state enum and the default timeouts there.
- One sub-module is natural: spi_arb_timer, a loadable down-counter with an expiry flag, shared by WAIT and HOLD.

Test Plan:
1. req0, ss0=SS_EEPROM, data0=16'h4A55, lock0=0 -> next cycle gnt0, wrt_SPI pulse, SPI_data=4A55, ss=SS_EEPROM. Then SPI_done 20 cycles later with EEP_data=8'h3C -> next cycle done0=1, rd_data=3C, ss=SS_NONE.
2. After reset, req0 and req1 raised in the same cycle, repeated twice -> grants in order 0,1,0,1. Each wrt_SPI is separated by its SPI_done.
3. req1 with lock1=1 while req0 pending -> after done1, req1 re-raised within 5 cycles is served before req0. The next req1 with lock1=0 releases the bus, then req0 is granted.
4. req0 with lock0=1, no follow-up, req1 pending -> HOLD exits after exactly 16 cycles. gnt1 appears one cycle later.
5. SPI_done pulsed in IDLE -> no done0/done1, spurious_done=1 until reset.
6. Transfer granted, SPI_done never arrives -> done pulse at cycle 1024+1 with timeout_err=1. A second run with rst_n pulled low mid-WAIT -> all outputs return to reset values within the same cycle.
